// File: rtl/bxu_out_buf_if.sv
// Capture handshake from the execution unit and byte stream to the sink.
// master = execution unit + sink side, slave = the output buffer.
interface bxu_out_buf_if #(
  parameter int DATA_BITWIDTH = 8,
  parameter int DEPTH_LOG2    = 4
);
  logic [DATA_BITWIDTH-1:0] data_out;
  logic                     io_output_ready;
  logic                     io_output_done;
  logic [DATA_BITWIDTH-1:0] tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [DEPTH_LOG2:0]      level;
  logic                     full;

  modport master (
    output data_out, io_output_ready, tx_ready,
    input  io_output_done, tx_data, tx_valid, level, full
  );

  modport slave (
    input  data_out, io_output_ready, tx_ready,
    output io_output_done, tx_data, tx_valid, level, full
  );
endinterface

// File: rtl/bxu_out_buf.sv
// Output byte buffer: one capture per io_output_ready assertion period,
// stored in a first-word-fall-through FIFO drained by a valid/ready sink.
module bxu_out_buf #(
  parameter int DATA_BITWIDTH = 8,
  parameter int DEPTH_LOG2    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  bxu_out_buf_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2+1)'(1);

  typedef enum logic [1:0] {IDLE, ACK, RELEASE} cap_state_e;

  cap_state_e               state, state_nxt;
  logic [DEPTH_LOG2:0]      wr_ptr, rd_ptr;
  logic [DATA_BITWIDTH-1:0] mem [DEPTH];
  logic                     wr_en, rd_en, empty, full_w, done_q;

  // Extra pointer MSB tells full (MSBs differ) from empty (all equal).
  assign empty  = (wr_ptr == rd_ptr);
  assign full_w = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign rd_en  = !empty && bus.tx_ready;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.io_output_ready && !full_w) begin
          wr_en     = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = RELEASE;
      // Hold here until the request drops so a long request yields one byte.
      RELEASE: if (!bus.io_output_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= wr_en;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.data_out;
  end

  assign bus.io_output_done = done_q;
  assign bus.tx_data        = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign bus.tx_valid       = !empty;
  assign bus.level          = wr_ptr - rd_ptr;
  assign bus.full           = full_w;
endmodule

// File: tb/tb_bxu_out_buf.sv
// Bench for bxu_out_buf: vector table, directed handshake/FIFO corner cases,
// then random traffic against a queue-based reference model.
module tb_bxu_out_buf;
  localparam int DW    = 8;
  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bxu_out_buf_if #(.DATA_BITWIDTH(DW), .DEPTH_LOG2(DL2)) bif();
  bxu_out_buf #(.DATA_BITWIDTH(DW), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model: byte queue plus "request has dropped since last capture"
  logic [DW-1:0] mq[$];
  bit            m_idle = 1'b1;
  int            m_cnt  = 0;
  bit            m_done = 1'b0;
  bit            model_on  = 1'b0;
  bit            sink_on   = 1'b0;
  bit            toggle_on = 1'b0;
  logic [DW-1:0] rx[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_edge();
    bit wr, rd;
    if (!rst_n) begin
      mq.delete();
      m_idle = 1'b1; m_cnt = 0; m_done = 1'b0;
      return;
    end
    wr = m_idle && bif.io_output_ready && (mq.size() < DEPTH);
    rd = (mq.size() > 0) && bif.tx_ready;
    if (rd) void'(mq.pop_front());
    if (wr) mq.push_back(bif.data_out);
    if (wr) begin
      m_idle = 1'b0; m_cnt = 0;
    end else if (!m_idle) begin
      // the first edge after a capture ignores the request level
      if (m_cnt >= 1 && !bif.io_output_ready) m_idle = 1'b1;
      m_cnt++;
    end
    m_done = wr;
  endfunction

  task automatic compare_model();
    chk("model done",  int'(bif.io_output_done), int'(m_done));
    chk("model valid", int'(bif.tx_valid), int'(mq.size() > 0));
    if (mq.size() > 0) chk("model data", int'(bif.tx_data), int'(mq[0]));
    chk("model level", int'(bif.level), mq.size());
    chk("model full",  int'(bif.full), int'(mq.size() == DEPTH));
  endtask

  task automatic step();
    if (sink_on && bif.tx_valid && bif.tx_ready) rx.push_back(bif.tx_data);
    model_edge();
    @(posedge clk);
    #1;
    if (toggle_on) bif.tx_ready = !bif.tx_ready;
    if (model_on) compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin step(); n++; end while (!bif.io_output_done && n < 60);
    chk({name, " done timeout"}, int'(bif.io_output_done), 1);
  endtask

  task automatic drain_to(input int cnt, input string name);
    int n = 0;
    while (rx.size() < cnt && n < 400) begin step(); n++; end
    chk({name, " rx count"}, rx.size(), cnt);
  endtask

  typedef struct {
    logic rdy; logic [DW-1:0] d; logic txr;
    logic e_done; logic e_valid; logic [DW-1:0] e_data; int e_level;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dones, vcnt, bias;
    bit seen41;
    rst_n = 1'b0;
    bif.io_output_ready = 1'b0;
    bif.data_out = '0;
    bif.tx_ready = 1'b0;
    #2;
    chk("reset done",  int'(bif.io_output_done), 0);
    chk("reset valid", int'(bif.tx_valid), 0);
    chk("reset level", int'(bif.level), 0);
    chk("reset full",  int'(bif.full), 0);
    step();
    rst_n = 1'b1;

    // rdy, data, txr | done, valid, data, level
    tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 8'h41, 1};
    tbl[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 8'h41, 1};
    tbl[2]  = '{1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    tbl[3]  = '{1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 0};
    tbl[4]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 8'h10, 1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10, 1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10, 1};
    tbl[7]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    tbl[10] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1};
    for (int i = 0; i < 11; i++) begin
      bif.io_output_ready = tbl[i].rdy;
      bif.data_out        = tbl[i].d;
      bif.tx_ready        = tbl[i].txr;
      step();
      chk($sformatf("vec%0d done", i),  int'(bif.io_output_done), int'(tbl[i].e_done));
      chk($sformatf("vec%0d valid", i), int'(bif.tx_valid), int'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("vec%0d data", i), int'(bif.tx_data), int'(tbl[i].e_data));
      chk($sformatf("vec%0d level", i), int'(bif.level), tbl[i].e_level);
      chk($sformatf("vec%0d full", i),  int'(bif.full), 0);
    end
    bif.io_output_ready = 1'b0; bif.tx_ready = 1'b1;
    repeat (3) step();

    // single byte with a long request
    dones = 0; vcnt = 0; seen41 = 1'b0;
    bif.io_output_ready = 1'b1; bif.data_out = 8'h41; bif.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) bif.io_output_ready = 1'b0;
      step();
      dones += int'(bif.io_output_done);
      if (bif.tx_valid) begin
        vcnt++;
        if (bif.tx_data == 8'h41) seen41 = 1'b1;
      end
    end
    chk("single done pulses", dones, 1);
    chk("single valid cycles", vcnt, 1);
    chk("single data", int'(seen41), 1);
    chk("single level", int'(bif.level), 0);

    // fill to full, then a stalled 17th request
    bif.tx_ready = 1'b0;
    dones = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bif.data_out = DW'(i); bif.io_output_ready = 1'b1;
      step();
      dones += int'(bif.io_output_done);
      bif.io_output_ready = 1'b0;
      step(); step();
    end
    chk("fill dones", dones, DEPTH);
    chk("fill level", int'(bif.level), DEPTH);
    chk("fill full", int'(bif.full), 1);
    chk("fill head", int'(bif.tx_data), 0);
    dones = 0;
    bif.data_out = 8'h10; bif.io_output_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      dones += int'(bif.io_output_done);
    end
    chk("stall no done", dones, 0);
    chk("stall level", int'(bif.level), DEPTH);
    bif.tx_ready = 1'b1;
    step();
    chk("unstall read done", int'(bif.io_output_done), 0);
    chk("unstall read level", int'(bif.level), DEPTH - 1);
    chk("unstall head", int'(bif.tx_data), 1);
    bif.tx_ready = 1'b0;
    step();
    chk("late capture done", int'(bif.io_output_done), 1);
    chk("late capture level", int'(bif.level), DEPTH);
    chk("late capture full", int'(bif.full), 1);
    bif.io_output_ready = 1'b0; bif.tx_ready = 1'b1;
    rx.delete(); sink_on = 1'b1;
    drain_to(DEPTH, "fill drain");
    for (int i = 0; i < rx.size(); i++) chk($sformatf("fill order %0d", i), int'(rx[i]), i + 1);
    sink_on = 1'b0;
    repeat (2) step();

    // 40 bytes through a toggling sink, pointers wrap twice
    do_reset();
    rx.delete(); sink_on = 1'b1; toggle_on = 1'b1; bif.tx_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bif.data_out = DW'(i); bif.io_output_ready = 1'b1;
      wait_done($sformatf("wrap byte %0d", i));
      bif.io_output_ready = 1'b0;
      step(); step();
    end
    drain_to(40, "wrap");
    for (int i = 0; i < rx.size(); i++) chk($sformatf("wrap order %0d", i), int'(rx[i]), i);
    sink_on = 1'b0; toggle_on = 1'b0;
    bif.tx_ready = 1'b1;
    repeat (3) step();

    // reset while in ACK, request still held afterwards
    bif.tx_ready = 1'b0; bif.data_out = 8'hAA; bif.io_output_ready = 1'b1;
    step();
    chk("ack capture done", int'(bif.io_output_done), 1);
    rst_n = 1'b0;
    #2;
    chk("ack reset done",  int'(bif.io_output_done), 0);
    chk("ack reset valid", int'(bif.tx_valid), 0);
    chk("ack reset level", int'(bif.level), 0);
    chk("ack reset full",  int'(bif.full), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("recapture done", int'(bif.io_output_done), 1);
    chk("recapture level", int'(bif.level), 1);
    chk("recapture data", int'(bif.tx_data), 8'hAA);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      dones += int'(bif.io_output_done);
    end
    chk("recapture once", dones, 0);
    chk("recapture hold level", int'(bif.level), 1);
    bif.io_output_ready = 1'b0; bif.tx_ready = 1'b1;
    repeat (3) step();
    chk("recapture drained", int'(bif.level), 0);

    // random traffic against the model
    do_reset();
    model_on = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      case (i / 500)
        0: bias = 10;
        1: bias = 90;
        2: bias = 50;
        default: bias = 30;
      endcase
      if ($urandom_range(0, 3) == 0) bif.io_output_ready = !bif.io_output_ready;
      bif.data_out = DW'($urandom);
      bif.tx_ready = ($urandom_range(0, 99) < bias);
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end
    model_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bxu_out_buf.md
BXU_OUT_BUF -- requirements
Module: bxu_out_buf

Interface
REQ-001 Parameter DATA_BITWIDTH, default 8: width of output bytes.
REQ-002 Parameter DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 data_out  input  DATA_BITWIDTH  byte presented by the execution unit for output.
REQ-006 io_output_ready  input  1  level request from the execution unit: data_out is valid and should be taken.
REQ-007 io_output_done  output  1  one-cycle acknowledge: byte has been captured.
REQ-008 tx_data  output  DATA_BITWIDTH  head-of-FIFO byte to the downstream sink.
REQ-009 tx_valid  output  1  FIFO non-empty; tx_data is valid.
REQ-010 tx_ready  input  1  sink accepts tx_data when tx_valid and tx_ready are both high at a rising edge.
REQ-011 level  output  DEPTH_LOG2+1  current number of stored entries.
REQ-012 full  output  1  level equals 2**DEPTH_LOG2.

Function
REQ-013 Capture FSM SHALL have three states: IDLE, ACK, RELEASE.
REQ-014 In IDLE, at a rising edge where io_output_ready=1 and full=0, the block SHALL write data_out into the FIFO and go to ACK.
REQ-015 In IDLE, with io_output_ready=1 and full=1, the block SHALL stay in IDLE, write nothing and keep io_output_done=0 (the execution unit stalls).
REQ-016 io_output_done SHALL be registered and high only while in ACK, for exactly one cycle per captured byte.
REQ-017 ACK SHALL move unconditionally to RELEASE on the next edge.
REQ-018 RELEASE SHALL return to IDLE on the first edge where io_output_ready=0; no capture occurs in RELEASE or ACK.
REQ-019 Each assertion period of io_output_ready SHALL produce exactly one FIFO write, regardless of its length.
REQ-020 Capture latency: byte written on edge N; io_output_done high in cycle N to N+1; earliest next capture on the edge after io_output_ready is seen low.
REQ-021 FIFO SHALL be first-word-fall-through: tx_data equals the oldest entry whenever tx_valid=1; tx_data is don't-care when tx_valid=0.
REQ-022 A write SHALL become visible on tx_valid in the cycle after the write edge.
REQ-023 A read occurs on every edge where tx_valid=1 and tx_ready=1; the read pointer advances by one.
REQ-024 Pointers SHALL be DEPTH_LOG2+1 bits wide and wrap modulo 2**(DEPTH_LOG2+1); full/empty SHALL be derived from pointer comparison; level = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1).
REQ-025 A simultaneous write and read SHALL leave level unchanged. When full=1, this is not allowed because a write is blocked while full.
REQ-026 A read SHALL never occur when empty; tx_ready while tx_valid=0 SHALL have no effect.
REQ-027 A simultaneous write and read on an entry that holds one item SHALL output the old item and then the new one, with no loss or duplication.
REQ-028 FIFO storage SHALL need no reset; pointer, FSM and output flags SHALL be reset.

Reset
REQ-029 While rst_n=0: FSM=IDLE, pointers=0, io_output_done=0, tx_valid=0, level=0, full=0, asynchronously.
REQ-030 Reset mid-handshake (ACK or RELEASE) SHALL abort to IDLE. After release, if io_output_ready is still high, it SHALL be treated as a new request.
REQ-031 Reset SHALL discard all buffered bytes.

Verification
REQ-032 Single byte: ready high with data_out=0x41 for 5 cycles, tx_ready=1 -> exactly one done pulse; tx_valid for 1 cycle with tx_data=0x41; level returns to 0.
REQ-033 Fill: DEPTH_LOG2=4, tx_ready=0, 16 requests with 0x00..0x0F -> level=16, full=1. A 17th request gets no done while held for 10 cycles. Then one tx_ready cycle -> 17th byte captured, next done pulse follows, full remains 1.
REQ-034 Wrap: 40 bytes 0x00..0x27 streamed with tx_ready toggling every cycle -> sink receives 0x00..0x27 in order with no loss or duplication; pointers wrap twice.
REQ-035 Simultaneous write/read: level=1 (0x10), capture 0x11 on the same edge as a read -> level stays 1 and tx_data=0x11 next cycle.
REQ-036 Reset in ACK: assert rst_n=0 for 1 cycle right after capture of 0xAA -> done=0, tx_valid=0, level=0. After release, if ready is still high, 0xAA is re-captured once.
